// File: rtl/sblk_sched_pkg.sv
// Shared types for the sblk row scheduler: FSM state encoding and a width helper
// used to size the round-robin pointer and the beat / start-timeout counters.
package sblk_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    START,
    ARB,
    BURST,
    DONE
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sblk_row_sched_rr_arb.sv
// Combinational round-robin pick: the first requester at or after ptr, wrapping
// modulo NUM_ROW, returned both one-hot and as an index.
module rr_arb #(
  parameter int NUM_ROW = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_ROW-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_ROW-1:0] gnt_oh,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  int cand;

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_ROW; i++) begin
      cand = (int'(ptr) + i) % NUM_ROW;
      if (!gnt_any && req[IDX_W'(cand)]) begin
        gnt_any                = 1'b1;
        gnt_idx                = IDX_W'(cand);
        gnt_oh[IDX_W'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sblk_row_sched.sv
// Layer sequencer for the sblk rows: parameter broadcast, round-robin activation
// bursts and completion reporting. Optional counters behind SBLK_SCHED_PERF_EN.
module sblk_row_sched
  import sblk_sched_pkg::*;
#(
  parameter int NUM_ROW   = 4,
  parameter int PARAM_LEN = 32,
  parameter int DATA_LEN  = 32,
  parameter int BURST_LEN = 16,
  parameter int START_TMO = 15
) (
  input  logic                 clk_l,
  input  logic                 rst_n,
  input  logic [PARAM_LEN-1:0] param_in,
  input  logic                 param_vld,
  output logic                 param_rdy,
  output logic [PARAM_LEN-1:0] sblk_param,
  output logic                 sblk_param_en,
  input  logic [NUM_ROW-1:0]   sblk_status,
  input  logic [DATA_LEN-1:0]  act_data,
  input  logic                 act_vld,
  output logic                 act_rdy,
  output logic [DATA_LEN-1:0]  actbuf_wr_data,
  input  logic [NUM_ROW-1:0]   actbuf_wr_req,
  output logic [NUM_ROW-1:0]   actbuf_wr_vld,
  output logic                 layer_done,
  output logic                 sched_err
`ifdef SBLK_SCHED_PERF_EN
  ,
  output logic [31:0]          perf_busy,
  output logic [31:0]          perf_stall
`endif
);

  localparam int PTR_W  = width_of(NUM_ROW);
  localparam int BEAT_W = width_of(BURST_LEN + 1);
  localparam int TMO_W  = width_of(START_TMO + 1);

  state_t              state, state_nx;
  logic [PTR_W-1:0]    ptr, grant, arb_idx;
  logic [NUM_ROW-1:0]  grant_oh, arb_oh;
  logic                arb_any;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                alive;
  logic                accept, last_beat, tmo_hit;

  rr_arb #(
    .NUM_ROW (NUM_ROW),
    .IDX_W   (PTR_W)
  ) u_arb (
    .req     (actbuf_wr_req),
    .ptr     (ptr),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign act_rdy   = (state == BURST);
  assign accept    = act_rdy && act_vld;
  assign last_beat = accept && (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign tmo_hit   = (state == START) && (sblk_status == '0) &&
                     (tmo_cnt == TMO_W'(START_TMO - 1));

  always_comb begin
    state_nx  = state;
    param_rdy = 1'b0;
    unique case (state)
      IDLE: begin
        // alive keeps the host handshake closed while reset is held.
        param_rdy = alive && (sblk_status == '0);
        if (param_vld && param_rdy) state_nx = CFG;
      end
      CFG:   state_nx = START;
      START: begin
        if (sblk_status != '0) state_nx = ARB;
        else if (tmo_hit)      state_nx = IDLE;
      end
      ARB: begin
        if (arb_any)                 state_nx = BURST;
        else if (sblk_status == '0)  state_nx = DONE;
      end
      BURST: if (last_beat) state_nx = ARB;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      alive          <= 1'b0;
      ptr            <= '0;
      grant          <= '0;
      grant_oh       <= '0;
      beat_cnt       <= '0;
      tmo_cnt        <= '0;
      sblk_param_en  <= 1'b0;
      layer_done     <= 1'b0;
      sched_err      <= 1'b0;
      actbuf_wr_vld  <= '0;
      sblk_param     <= '0;
      actbuf_wr_data <= '0;
    end else begin
      state         <= state_nx;
      alive         <= 1'b1;
      sblk_param_en <= (state_nx == CFG);
      layer_done    <= (state_nx == DONE) || tmo_hit;
      sched_err     <= sched_err || tmo_hit;

      if (state == CFG)        tmo_cnt <= '0;
      else if (state == START) tmo_cnt <= tmo_cnt + 1'b1;

      // Grant is latched for the whole burst, whatever req does afterwards.
      if (state == ARB && arb_any) begin
        grant    <= arb_idx;
        grant_oh <= arb_oh;
        beat_cnt <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end

      if (last_beat) ptr <= (grant == PTR_W'(NUM_ROW - 1)) ? '0 : grant + 1'b1;

      actbuf_wr_vld <= accept ? grant_oh : '0;
      if (param_vld && param_rdy) sblk_param     <= param_in;
      if (accept)                 actbuf_wr_data <= act_data;
    end
  end

`ifdef SBLK_SCHED_PERF_EN
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else if (state == IDLE && state_nx == CFG) begin
      perf_busy  <= '0;
      perf_stall <= '0;
    end else begin
      if (state != IDLE && perf_busy != '1) perf_busy <= perf_busy + 1'b1;
      if (state == BURST && !act_vld && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: doc/sblk_row_sched.md
Name: sblk_row_sched

Overview:
- Top-level sequencer for the NUM_ROW sblk_row instances (one per HW_D3 position).
- Accepts layer parameter words from the host and broadcasts each to every row as a one-cycle sblk_param_en pulse.
- While the rows run, shares the single activation source stream among the rows' actbuf_wr_req lines with round-robin, fixed-length bursts.
- Reports layer completion once every row's sblk_status has returned low.

Parameters:
- NUM_ROW, 4: number of sblk_row instances (HW_D3).
- PARAM_LEN, 32: sblk_param width (HW_XLT_LEN).
- DATA_LEN, 32: activation beat width (2*ACTBUF_DATA_LEN).
- BURST_LEN, 16: beats per granted burst; must be ≥1.
- START_TMO, 15: maximum cycles to wait for any row to report busy after a parameter pulse.

Ports:
- clk_l  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- param_in  in  PARAM_LEN  host parameter word.
- param_vld  in  1  host parameter valid.
- param_rdy  out  1  host parameter ready.
- sblk_param  out  PARAM_LEN  parameter word broadcast to all rows.
- sblk_param_en  out  1  one-cycle broadcast strobe.
- sblk_status  in  NUM_ROW  per-row busy; 1 = busy.
- act_data  in  DATA_LEN  activation source data.
- act_vld  in  1  activation source valid.
- act_rdy  out  1  activation source ready.
- actbuf_wr_data  out  DATA_LEN  shared data bus to rows; registered copy of act_data.
- actbuf_wr_req  in  NUM_ROW  per-row request for a burst.
- actbuf_wr_vld  out  NUM_ROW  one-hot beat valid to the granted row.
- layer_done  out  1  one-cycle completion pulse.
- sched_err  out  1  sticky start-timeout flag.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; sched_err 0.
- FSM transitions:
  - IDLE: param_rdy=1 only when sblk_status==0. On param_vld&param_rdy, capture param_in into sblk_param and go to CFG.
  - CFG: sblk_param_en=1 for exactly one cycle, then go to START.
  - START: count cycles. If any sblk_status bit is 1, go to ARB. If the count reaches START_TMO, set sched_err, pulse layer_done, and go to IDLE.
  - ARB: if actbuf_wr_req has any bit set, grant the first requesting index at or after the pointer (wrapping modulo NUM_ROW), clear the beat count, and go to BURST. If no request and sblk_status==0, go to DONE.
  - BURST: act_rdy=1. Each cycle with act_vld=1 registers act_data into actbuf_wr_data and sets actbuf_wr_vld[grant] for the next cycle (1-cycle latency). On the BURST_LEN-th accepted beat, set pointer = grant+1 (wrapping) and return to ARB.
  - DONE: layer_done=1 for one cycle, then go to IDLE.
- act_rdy is 0 in every state except BURST. No beat is accepted on the ARB→BURST transition cycle.
- If the granted row's req drops mid-burst, the burst still completes: the grant is locked for BURST_LEN beats.
- If sblk_status drops to 0 mid-burst, the burst still completes, then ARB evaluates again.
- The beat counter is $clog2(BURST_LEN+1) bits wide; the pointer is $clog2(NUM_ROW) bits wide and wraps from NUM_ROW-1 to 0.
- Parameter words arriving while the rows are busy are back-pressured with param_rdy=0.
- Reset asserted mid-burst aborts immediately. The beat in flight is lost; the upstream source must replay it.
- sched_err is cleared only by reset.

Optional Feature:
- Macro SBLK_SCHED_PERF_EN.
- When defined, adds output perf_busy [31:0] and output perf_stall [31:0]:
  - perf_busy counts cycles not in IDLE.
  - perf_stall counts BURST cycles with act_vld=0.
  - Both counters saturate at all-ones and are cleared when state moves from IDLE to CFG.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package sblk_sched_pkg holds the state enum (IDLE, CFG, START, ARB, BURST, DONE) and the width helper function for the pointer and counters.
- One sub-module, rr_arb: combinational round-robin pick of the next requester from req and pointer, output as one-hot plus index.

Test Plan:
- Basic layer: NUM_ROW=4, param 0x00A5_0001, rows raise status 3 cycles after the strobe, row 2 requests one burst → one sblk_param_en pulse carrying 0x00A5_0001; 16 beats appear on actbuf_wr_vld[2] only, one cycle after acceptance; layer_done fires once after status clears.
- Fairness: all four rows hold req continuously for 8 bursts → grant order 0,1,2,3,0,1,2,3; every burst is exactly 16 beats.
- Source stalls: act_vld toggles every other cycle during a burst → 16 beats delivered over 32 cycles; with SBLK_SCHED_PERF_EN, perf_stall=16.
- Back-pressure: second param_vld while status=4'b0010 → param_rdy stays 0 until status=0; then the second parameter is accepted and broadcast.
- Timeout: rows never assert status after the strobe → sched_err=1 and layer_done pulse at cycle START_TMO (15) after START entry; block returns to IDLE.
- Reset mid-burst: rst_n low after beat 7 → all outputs are 0 immediately; after release, state is IDLE with pointer 0.
